run_job_arbiter: RTL
====================

Name: run_job_arbiter

Overview:
- Shares one run/done worker (start pulse in, done level/pulse out) among NUM_REQ requesters.
- Picks a requester round-robin, issues a one-cycle start to the worker and waits for done.
- Returns a one-cycle ack to the winning requester, or an error pulse if the worker does not answer within TIMEOUT_CYCLES.
- Sits between client blocks and the worker FSM; the worker needs no changes.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, width of grant index; must equal ceil(log2(NUM_REQ)).
- TIMEOUT_CYCLES, 16, maximum WAIT cycles before abort (2..2^CNT_W).
- CNT_W, 5, width of timeout counter.

Ports:
- i_clock  input  1  system clock, rising edge.
- i_reset_async_n  input  1  reset, asynchronous assert, active low.
- i_req  input  NUM_REQ  per-requester job request, level; held until ack or error for that requester.
- o_run  output  1  start pulse to worker; high exactly one cycle per job.
- i_worker_done  input  1  worker completion; sampled only in WAIT.
- o_ack  output  NUM_REQ  one-hot, one-cycle pulse: job of that requester completed.
- o_error  output  NUM_REQ  one-hot, one-cycle pulse: job of that requester timed out.
- o_grant_id  output  ID_W  index of current or last granted requester.
- o_busy  output  1  high in every state except IDLE.

Behaviour:
- One clock domain. Reset is asynchronous and active-low; there is one clock. Reset is applied on the negedge of i_reset_async_n and released synchronously by the design's reset tree.
- Reset values:
  - state = IDLE.
  - o_run = 0, o_ack = 0, o_error = 0, o_busy = 0.
  - o_grant_id = 0.
  - timeout counter = 0.
  - round-robin pointer = NUM_REQ-1, so index 0 has first priority.
- States (2-bit encoding): IDLE=00, ISSUE=01, WAIT=10, RESP=11.
- IDLE:
  - If any i_req bit is set, select the first set bit searching from pointer+1 upward with wrap-around.
  - Register the selected index into o_grant_id and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - o_run = 1; clear the counter; go to WAIT unconditionally.
  - i_worker_done is ignored in ISSUE (stale done from a previous job).
- WAIT:
  - If i_worker_done = 1, go to RESP with status OK.
  - Else if counter == TIMEOUT_CYCLES-1, go to RESP with status TIMEOUT.
  - Else increment the counter.
  - If done and the limit occur in the same cycle, done wins (status OK).
- RESP:
  - o_ack[o_grant_id] = 1 if status OK, else o_error[o_grant_id] = 1. Exactly one of the two fires.
  - Set pointer = o_grant_id; go to IDLE.
- Outputs o_run, o_ack, o_error and o_busy are decoded from registered state plus registered id/status only. There is no combinational path from inputs to outputs.
- Latency with a worker that raises done two cycles after its start edge:
  - req sampled at edge 0
  - o_run high in cycle 1
  - done in cycle 3
  - ack in cycle 4
  - IDLE in cycle 5
  - a pending request gets its o_run in cycle 6
- Fairness: a requester that holds i_req is served after at most NUM_REQ-1 other jobs.
- A requester dropping i_req after being granted does not cancel the job. The job runs to completion and ack/error is still pulsed.
- Requests are not re-sampled outside IDLE. A requester whose i_req is still high in the cycle after its ack is treated as a new job.
- Reset mid-job: all state is cleared immediately and no ack/error is issued for the aborted job. The worker is reset by the same signal.
- The counter never exceeds TIMEOUT_CYCLES-1; there is no wrap.

Test Plan:
- Reset, then i_req=4'b0001 held; worker done 2 cycles after o_run -> o_run in cycle 1, o_ack=4'b0001 in cycle 4 only, o_grant_id=0, o_busy high in cycles 1-4.
- i_req=4'b1111 held for 4 jobs -> grant order 0,1,2,3, then 0 again; each requester receives exactly one ack per job; o_run pulses spaced 5 cycles apart.
- i_req=4'b0100 with worker done stuck at 0, TIMEOUT_CYCLES=16 -> o_error=4'b0100 exactly 16 WAIT cycles after ISSUE, o_ack stays 0, o_busy drops the next cycle.
- Worker done asserted in the same cycle the counter reaches 15 -> o_ack pulses and o_error stays 0. Done pulse during ISSUE only -> ignored, state stays in WAIT.
- i_req=4'b0010 pulsed for 1 cycle -> job still runs and o_ack=4'b0010 is issued. With i_req[1] and i_req[3] set and the pointer at 1 -> grant 3 first.
- Reset asserted while in WAIT -> outputs go to reset values immediately, no ack/error pulse; after release the same held request is re-granted from index 0 priority.

Source files
------------

// File: rtl/run_job_arbiter_if.sv
// ---------------------------------------------------------------------------
// run_job_arbiter_if
//   Bundles the requester-side and worker-side handshake of the run/done
//   job arbiter.
//
//   i_req          requester job requests (level, one bit per requester)
//   o_run          one-cycle start pulse to the shared worker
//   i_worker_done  worker completion
//   o_ack          one-hot completion pulse back to the granted requester
//   o_error        one-hot timeout pulse back to the granted requester
//   o_grant_id     index of the current / last granted requester
//   o_busy         arbiter is handling a job
//
//   slave  : arbiter side
//   master : requester/worker side
// ---------------------------------------------------------------------------
interface run_job_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0] i_req;
    logic               o_run;
    logic               i_worker_done;
    logic [NUM_REQ-1:0] o_ack;
    logic [NUM_REQ-1:0] o_error;
    logic [ID_W-1:0]    o_grant_id;
    logic               o_busy;

    modport slave (
        input  i_req,
        input  i_worker_done,
        output o_run,
        output o_ack,
        output o_error,
        output o_grant_id,
        output o_busy
    );

    modport master (
        output i_req,
        output i_worker_done,
        input  o_run,
        input  o_ack,
        input  o_error,
        input  o_grant_id,
        input  o_busy
    );
endinterface

// File: rtl/run_job_arbiter.sv
// ---------------------------------------------------------------------------
// run_job_arbiter
//   Shares one run/done worker among NUM_REQ requesters. Picks a requester
//   round-robin, pulses o_run for one cycle, waits for i_worker_done and
//   answers the winner with a one-cycle o_ack, or with o_error if the worker
//   stays silent for TIMEOUT_CYCLES wait cycles.
//
//   i_clock          system clock, rising edge
//   i_reset_async_n  asynchronous active-low reset
//   bus (slave)      i_req, i_worker_done in; o_run, o_ack, o_error,
//                    o_grant_id, o_busy out (all outputs registered)
// ---------------------------------------------------------------------------
module run_job_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic           i_clock,
    input  logic           i_reset_async_n,
    run_job_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    grant;
    logic [CNT_W-1:0]   cnt;
    logic               run_q;
    logic               busy_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [NUM_REQ-1:0] err_q;

    logic               sel_found;
    logic [ID_W-1:0]    sel_id;
    logic [ID_W-1:0]    cand;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        return NUM_REQ'(1) << id;
    endfunction

    // Round-robin search: first set request strictly after the pointer,
    // wrapping around, so the last served requester has lowest priority.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!sel_found && bus.i_req[cand]) begin
                sel_found = 1'b1;
                sel_id    = cand;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_async_n) begin
        if (!i_reset_async_n) begin
            state  <= IDLE;
            ptr    <= ID_W'(NUM_REQ - 1);
            grant  <= '0;
            cnt    <= '0;
            run_q  <= 1'b0;
            busy_q <= 1'b0;
            ack_q  <= '0;
            err_q  <= '0;
        end else begin
            // Pulse outputs default low; each is raised for exactly one cycle.
            run_q <= 1'b0;
            ack_q <= '0;
            err_q <= '0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant  <= sel_id;
                        run_q  <= 1'b1;
                        busy_q <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Done is not looked at here: it may be left over from
                    // the previous job.
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // Done takes precedence over the timeout limit.
                    if (bus.i_worker_done) begin
                        ack_q <= onehot(grant);
                        state <= RESP;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        err_q <= onehot(grant);
                        state <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    ptr    <= grant;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_run      = run_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_ack      = ack_q;
    assign bus.o_error    = err_q;
    assign bus.o_grant_id = grant;

endmodule
